// File: rtl/st_pkt_sf_fifo_if.sv
// Avalon-ST style packet stream interface shared by st_encoder and st_pkt_sf_fifo.
interface st_pkt_intf #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3
);
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               valid;
    logic               ready;

    modport master (
        output data, sop, eop, empty, valid,
        input  ready
    );

    modport slave (
        input  data, sop, eop, empty, valid,
        output ready
    );
endinterface

// File: rtl/st_pkt_sf_fifo.sv
// Store-and-forward packet FIFO: a packet becomes visible downstream only once
// its eop beat is stored. Oversize packets and broken framing are dropped whole.
module st_pkt_sf_fifo #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int DEPTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    st_pkt_intf.slave                i_pkt_intf,
    st_pkt_intf.master               o_pkt_intf,
    output logic [$clog2(DEPTH):0]   o_pkt_cnt,
    output logic                     o_drop,
    output logic                     o_err
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int BEAT_W = DATA_W + 2 + EMPTY_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    wr_state_e              state_r;
    wr_state_e              state_nxt_s;
    logic [BEAT_W-1:0]      mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       commit_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       used_s;
    logic [PTR_W-1:0]       wr_base_s;
    logic                   full_s;
    logic                   in_ready_s;
    logic                   in_fire_s;
    logic                   out_valid_s;
    logic                   out_fire_s;
    logic                   rd_eop_fire_s;
    logic                   overflow_s;
    logic                   wr_en_s;
    logic                   commit_en_s;
    logic                   rewind_s;
    logic                   err_s;
    logic                   drop_s;
    logic [BEAT_W-1:0]      rd_beat_s;

    assign used_s     = wr_ptr_r - rd_ptr_r;
    assign full_s     = (used_s == PTR_W'(DEPTH));
    // A partial packet that fills the buffer on its own can never be committed.
    assign overflow_s = full_s && (commit_ptr_r == rd_ptr_r);
    assign in_ready_s = (state_r == ST_DROP) ? 1'b1 : !full_s;
    assign in_fire_s  = i_pkt_intf.valid && in_ready_s;
    assign i_pkt_intf.ready = in_ready_s;

    assign out_valid_s   = (rd_ptr_r != commit_ptr_r);
    assign out_fire_s    = out_valid_s && o_pkt_intf.ready;
    assign rd_beat_s     = mem_r[rd_ptr_r[AW-1:0]];
    assign rd_eop_fire_s = out_fire_s && rd_beat_s[EMPTY_W];

    assign o_pkt_intf.valid = out_valid_s;
    assign o_pkt_intf.data  = rd_beat_s[BEAT_W-1 -: DATA_W];
    assign o_pkt_intf.sop   = rd_beat_s[EMPTY_W+1];
    assign o_pkt_intf.eop   = rd_beat_s[EMPTY_W];
    assign o_pkt_intf.empty = rd_beat_s[EMPTY_W-1:0];

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s && i_pkt_intf.sop && !i_pkt_intf.eop) begin
                    state_nxt_s = ST_PKT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PKT: begin
                if (overflow_s) begin
                    state_nxt_s = ST_DROP;
                end else if (in_fire_s && i_pkt_intf.eop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PKT;
                end
            end
            ST_DROP: begin
                if (in_fire_s && i_pkt_intf.eop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Write FSM actions: which slot to write, commits, rewinds and event pulses.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_base_s   = wr_ptr_r;
        commit_en_s = 1'b0;
        rewind_s    = 1'b0;
        err_s       = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s && i_pkt_intf.sop) begin
                    wr_en_s     = 1'b1;
                    commit_en_s = i_pkt_intf.eop;
                end else if (in_fire_s) begin
                    err_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_PKT: begin
                if (overflow_s) begin
                    rewind_s = 1'b1;
                    drop_s   = 1'b1;
                end else if (in_fire_s && i_pkt_intf.sop) begin
                    // Missing eop: restart the packet at the last committed slot.
                    err_s       = 1'b1;
                    wr_base_s   = commit_ptr_r;
                    wr_en_s     = 1'b1;
                    commit_en_s = i_pkt_intf.eop;
                end else if (in_fire_s) begin
                    wr_en_s     = 1'b1;
                    commit_en_s = i_pkt_intf.eop;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_DROP: begin
                wr_en_s = 1'b0;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Beat storage; contents need no reset since pointers guard every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_base_s[AW-1:0]] <= {i_pkt_intf.data, i_pkt_intf.sop,
                                         i_pkt_intf.eop, i_pkt_intf.empty};
        end
    end

    // Pointer, packet count and event pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            commit_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            o_pkt_cnt    <= {PTR_W{1'b0}};
            o_drop       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_base_s + PTR_W'(1);
            end else if (rewind_s) begin
                wr_ptr_r <= commit_ptr_r;
            end
            if (commit_en_s) begin
                commit_ptr_r <= wr_base_s + PTR_W'(1);
            end
            if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({commit_en_s, rd_eop_fire_s})
                2'b10:   o_pkt_cnt <= o_pkt_cnt + PTR_W'(1);
                2'b01:   o_pkt_cnt <= o_pkt_cnt - PTR_W'(1);
                default: o_pkt_cnt <= o_pkt_cnt;
            endcase
            o_drop <= drop_s;
            o_err  <= err_s;
        end
    end
endmodule

// File: tb/tb_st_pkt_sf_fifo.sv
// Directed self-checking bench for st_pkt_sf_fifo (DEPTH=8).
module tb_st_pkt_sf_fifo;
    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int BW      = DATA_W + 2 + EMPTY_W;

    typedef logic [BW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] pkt_cnt;
    logic          drop;
    logic          err;

    int errors = 0;
    int checks = 0;

    beat_t rx_q[$];
    int    drop_cnt = 0;
    int    err_cnt  = 0;

    st_pkt_intf #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) in_if ();
    st_pkt_intf #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) out_if ();

    st_pkt_sf_fifo #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_pkt_intf (in_if),
        .o_pkt_intf (out_if),
        .o_pkt_cnt  (pkt_cnt),
        .o_drop     (drop),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Output monitor: records transfers and event pulses mid-cycle.
    always @(negedge clk) begin
        if (out_if.valid === 1'b1 && out_if.ready === 1'b1)
            rx_q.push_back({out_if.data, out_if.sop, out_if.eop, out_if.empty});
        if (drop === 1'b1) drop_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e,
                                 input logic [2:0] emp);
        return {d, s, e, emp};
    endfunction

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] emp);
        bit ok = 1'b0;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = emp;
        in_if.valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (in_if.ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h ready=%b required 1", d, in_if.ready);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    // Wait (bounded) until the monitor holds target beats, then settle.
    task automatic wait_rx(input int target, input string name);
        for (int n = 0; n < 100 && rx_q.size() < target; n++) @(negedge clk);
        if (rx_q.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=%0d beats required %0d", name, rx_q.size(), target);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_if.valid = 1'b0; in_if.data = '0; in_if.sop = 1'b0;
        in_if.eop = 1'b0; in_if.empty = '0;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_if.ready); end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_if.valid); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
        checks++; if (drop !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got drop=%b err=%b exp 0 0", drop, err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        beat_t exp_q[$];
        int base = rx_q.size();
        out_if.ready = 1'b1;
        exp_q.push_back(mk(64'h11, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h22, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h33, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h44, 1'b0, 1'b1, 3'd2));
        send_beat(64'h11, 1'b1, 1'b0, 3'd0);
        send_beat(64'h22, 1'b0, 1'b0, 3'd0);
        send_beat(64'h33, 1'b0, 1'b0, 3'd0);
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", out_if.valid); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL single_cnt_pre got=%0d exp=0", pkt_cnt); end
        send_beat(64'h44, 1'b0, 1'b1, 3'd2);
        checks++; if (out_if.valid !== 1'b1) begin errors++; $display("FAIL single_release got=%b exp=1", out_if.valid); end
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt_held got=%0d exp=1", pkt_cnt); end
        wait_rx(base + 4, "single");
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL single_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL single_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL single_cnt_post got=%0d exp=0", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        beat_t exp_q[$];
        int base = rx_q.size();
        out_if.ready = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            for (int b = 1; b <= 3; b++) begin
                exp_q.push_back(mk(64'(p * 256 + b), b == 1, b == 3, (b == 3) ? 3'(p) : 3'd0));
            end
        end
        for (int k = 0; k < 8; k++) begin
            send_beat(exp_q[k][BW-1 -: DATA_W], exp_q[k][EMPTY_W+1], exp_q[k][EMPTY_W], exp_q[k][EMPTY_W-1:0]);
        end
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_if.ready); end
        checks++; if (pkt_cnt !== 4'd2) begin errors++; $display("FAIL bp_cnt got=%0d exp=2", pkt_cnt); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL bp_no_drop got=%0d exp=0", drop_cnt); end
        out_if.ready = 1'b1;
        send_beat(exp_q[8][BW-1 -: DATA_W], exp_q[8][EMPTY_W+1], exp_q[8][EMPTY_W], exp_q[8][EMPTY_W-1:0]);
        wait_rx(base + 9, "bp");
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL bp_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL bp_cnt_post got=%0d exp=0", pkt_cnt); end
    endtask

    task automatic test_oversize();
        beat_t exp_q[$];
        int base = rx_q.size();
        int d0 = drop_cnt;
        int e0 = err_cnt;
        out_if.ready = 1'b1;
        for (int k = 0; k < 10; k++) send_beat(64'h500 + 64'(k), k == 0, k == 9, 3'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL drop_pulses got=%0d exp=1", drop_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL drop_err got=%0d exp=0", err_cnt - e0); end
        checks++; if (rx_q.size() !== base) begin errors++; $display("FAIL drop_leak got=%0d beats exp=0", rx_q.size() - base); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL drop_cnt got=%0d exp=0", pkt_cnt); end
        exp_q.push_back(mk(64'h601, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h602, 1'b0, 1'b1, 3'd5));
        send_beat(64'h601, 1'b1, 1'b0, 3'd0);
        send_beat(64'h602, 1'b0, 1'b1, 3'd5);
        wait_rx(base + 2, "drop_follow");
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL drop_follow_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL drop_follow_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_missing_eop();
        beat_t exp_q[$];
        int base = rx_q.size();
        int e0 = err_cnt;
        out_if.ready = 1'b1;
        send_beat(64'h701, 1'b1, 1'b0, 3'd0);
        send_beat(64'h702, 1'b0, 1'b0, 3'd0);
        send_beat(64'h703, 1'b1, 1'b0, 3'd0);
        send_beat(64'h704, 1'b0, 1'b1, 3'd4);
        exp_q.push_back(mk(64'h703, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h704, 1'b0, 1'b1, 3'd4));
        wait_rx(base + 2, "noeop");
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL noeop_err got=%0d exp=1", err_cnt - e0); end
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL noeop_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL noeop_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
        // A beat without sop while idle is discarded and flagged.
        base = rx_q.size();
        e0 = err_cnt;
        send_beat(64'h801, 1'b0, 1'b0, 3'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL orphan_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (rx_q.size() !== base) begin errors++; $display("FAIL orphan_leak got=%0d beats exp=0", rx_q.size() - base); end
    endtask

    task automatic test_back_to_back();
        beat_t exp_q[$];
        int base = rx_q.size();
        out_if.ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(mk(64'h900 + 64'(k), 1'b1, 1'b1, 3'(k % 8)));
            send_beat(64'h900 + 64'(k), 1'b1, 1'b1, 3'(k % 8));
            checks++;
            if (pkt_cnt !== 4'd1 || out_if.valid !== 1'b1) begin
                errors++; $display("FAIL b2b_steady%0d got cnt=%0d valid=%b exp cnt=1 valid=1", k, pkt_cnt, out_if.valid);
            end
        end
        wait_rx(base + 20, "b2b");
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL b2b_cnt_post got=%0d exp=0", pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        beat_t exp_q[$];
        int base;
        out_if.ready = 1'b0;
        send_beat(64'hA01, 1'b1, 1'b1, 3'd0);
        send_beat(64'hB01, 1'b1, 1'b0, 3'd0);
        send_beat(64'hB02, 1'b0, 1'b0, 3'd0);
        in_if.data = 64'hB03; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.empty = 3'd0;
        in_if.valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_if.valid = 1'b0;
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_if.valid); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", pkt_cnt); end
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_if.ready); end
        out_if.ready = 1'b1;
        base = rx_q.size();
        exp_q.push_back(mk(64'hC01, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'hC02, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'hC03, 1'b0, 1'b1, 3'd7));
        send_beat(64'hC01, 1'b1, 1'b0, 3'd0);
        send_beat(64'hC02, 1'b0, 1'b0, 3'd0);
        send_beat(64'hC03, 1'b0, 1'b1, 3'd7);
        wait_rx(base + 3, "rstmid");
        checks++;
        if (rx_q.size() !== base + exp_q.size()) begin
            errors++; $display("FAIL rstmid_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (rx_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL rstmid_beat%0d got=%h exp=%h", k, rx_q[base+k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_oversize();
        test_missing_eop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
